// File: rtl/probit_pkg.sv
// Shared definitions for the probit period sequencer: FSM state encodings
// and a helper for sizing the period down-counter.
package probit_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CLEAR   = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    // Counter width able to hold NCLOCKS-1; never below one bit.
    function automatic int cnt_width(input int nclocks);
        return (nclocks > 1) ? $clog2(nclocks) : 1;
    endfunction

endpackage

// File: rtl/probit_result_hold.sv
// Single-entry valid/ready hold register for captured period results.
// A capture is accepted when the slot is empty or is being drained in the
// same clock; otherwise the new result is dropped and overrun latches.
module probit_result_hold #(
    parameter int W = 50
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic [W-1:0] d,
    input  logic         ready,
    output logic [W-1:0] q,
    output logic         valid,
    output logic         overrun
);

    logic accept;

    assign accept = capture && (!valid || ready);

    // Load on accept, drop valid after a handshake, latch overrun on a lost capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                q     <= d;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (capture && valid && !ready)
                overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/probit_period_sequencer.sv
// Drives the probit accumulator's ce/rst so it counts over exactly NCLOCKS
// clocks, captures the final gt/lt sums and hands them downstream as a
// tagged result over valid/ready. Single-shot or continuous with one dead
// clock (CAPTURE) between back-to-back periods.
module probit_period_sequencer
    import probit_pkg::*;
#(
    parameter int NBITS   = 21,
    parameter int NCLOCKS = 131072,
    parameter int SEQBITS = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               continuous_i,
    input  logic               abort_i,
    output logic               acc_ce_o,
    output logic               acc_rst_o,
    input  logic [NBITS-1:0]   gt_sum_i,
    input  logic [NBITS-1:0]   lt_sum_i,
    output logic [NBITS-1:0]   gt_o,
    output logic [NBITS-1:0]   lt_o,
    output logic [SEQBITS-1:0] seq_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               busy_o,
    output logic               overrun_o
);

    localparam int            CW       = cnt_width(NCLOCKS);
    localparam logic [CW-1:0] CNT_LOAD = CW'(NCLOCKS - 1);
    localparam int            RW       = 2 * NBITS + SEQBITS;

    typedef struct packed {
        logic [NBITS-1:0]   gt;
        logic [NBITS-1:0]   lt;
        logic [SEQBITS-1:0] seq;
    } probit_result_t;

    logic [1:0]         state;
    logic [1:0]         state_nx;
    logic [CW-1:0]      cnt;
    logic [SEQBITS-1:0] seq_cnt;
    logic               capture;
    probit_result_t     res_d;
    probit_result_t     res_q;

    // Next-state decode; abort beats continuous and start in any active state.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (start_i) state_nx = ST_CLEAR;
            ST_CLEAR:   state_nx = ST_RUN;
            ST_RUN:     if (cnt == '0) state_nx = ST_CAPTURE;
            ST_CAPTURE: state_nx = continuous_i ? ST_RUN : ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
        if (abort_i && state != ST_IDLE)
            state_nx = ST_IDLE;
    end

    // Sums are final in CAPTURE: the last ce edge closed the previous clock.
    assign capture = (state == ST_CAPTURE) && !abort_i;

    // Tag advances on every capture, including ones the hold stage drops,
    // so a skipped period shows up as a gap in the delivered tags.
    assign res_d = '{gt: gt_sum_i, lt: lt_sum_i, seq: seq_cnt + SEQBITS'(1)};

    // State, period counter, tag counter and registered accumulator controls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            seq_cnt   <= '0;
            acc_ce_o  <= 1'b0;
            acc_rst_o <= 1'b1;
            busy_o    <= 1'b0;
        end else begin
            state     <= state_nx;
            acc_ce_o  <= (state_nx == ST_RUN);
            acc_rst_o <= (state_nx != ST_RUN);
            busy_o    <= (state_nx != ST_IDLE);
            if (state_nx == ST_RUN && state != ST_RUN)
                cnt <= CNT_LOAD;
            else if (state == ST_RUN)
                cnt <= cnt - CW'(1);
            if (capture)
                seq_cnt <= seq_cnt + SEQBITS'(1);
        end
    end

    probit_result_hold #(
        .W (RW)
    ) u_hold (
        .clk     (clk_i),
        .rst     (rst_i),
        .capture (capture),
        .d       (res_d),
        .ready   (ready_i),
        .q       (res_q),
        .valid   (valid_o),
        .overrun (overrun_o)
    );

    assign gt_o  = res_q.gt;
    assign lt_o  = res_q.lt;
    assign seq_o = res_q.seq;

endmodule
